// File: rtl/traffic_phase_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | Package     : light_package                                                |
// | Description : Shared types and default timing for the traffic arbiter:    |
// |               lamp colours, phase and arbiter-state enums, phase count.    |
// |               The number of phases and the reset phase depend on          |
// |               TLC_PED_EN (pedestrian walk phase present when defined).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package light_package;

  typedef enum logic [1:0] {
    LIGHT_RED    = 2'd0,
    LIGHT_YELLOW = 2'd1,
    LIGHT_GREEN  = 2'd2
  } colors;

  typedef enum logic [1:0] {
    STR  = 2'd0,
    LEFT = 2'd1,
    NS   = 2'd2,
    PED  = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    ALLRED = 2'd2
  } arb_state_t;

  localparam int C_IDLE_CYC = 5;
  localparam int C_MAX_CYC  = 10;
  localparam int C_YEL_CYC  = 2;
  localparam int C_RED_CYC  = 1;
  localparam int C_WALK_CYC = 4;

`ifdef TLC_PED_EN
  localparam int     C_NUM_PHASES  = 4;
  localparam phase_t C_RESET_PHASE = PED;
`else
  localparam int     C_NUM_PHASES  = 3;
  localparam phase_t C_RESET_PHASE = NS;
`endif

endpackage

`default_nettype wire

// File: rtl/traffic_phase_arbiter_rr_pick.sv
// +----------------------------------------------------------------------------+
// | Module      : tlc_rr_pick                                                  |
// | Description : Combinational round-robin picker. Grants the first pending   |
// |               phase at or after (last+1) mod NUM_PHASES.                   |
// | Ports       : i_req   - pending request vector, one bit per phase          |
// |               i_last  - phase that held (or last held) right-of-way        |
// |               o_grant - chosen phase (equals i_last when nothing pending)  |
// |               o_valid - at least one request pending                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tlc_rr_pick
  import light_package::*;
#(
  parameter int NUM_PHASES = C_NUM_PHASES
) (
  input  logic [NUM_PHASES-1:0] i_req,
  input  phase_t                i_last,
  output phase_t                o_grant,
  output logic                  o_valid
);

  int w_dist;
  int w_best;

  // Distance 1..NUM_PHASES from the last phase; the last phase itself is
  // furthest away so it is only re-granted when nobody else is waiting.
  always_comb begin
    o_grant = i_last;
    o_valid = 1'b0;
    w_best  = NUM_PHASES + 1;
    w_dist  = 0;
    for (int j = 0; j < NUM_PHASES; j++) begin
      w_dist = (j - int'(i_last) + NUM_PHASES) % NUM_PHASES;
      if (w_dist == 0) begin
        w_dist = NUM_PHASES;
      end
      if (i_req[j] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_grant = phase_t'(j[1:0]);
        o_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/traffic_phase_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : traffic_phase_arbiter                                        |
// | Description : Round-robin right-of-way arbiter for a 3-street crossing     |
// |               with optional pedestrian walk phase (macro TLC_PED_EN).      |
// |               Each green is followed by yellow and all-red clearance.      |
// | Ports       : clk           - rising-edge clock                            |
// |               reset         - asynchronous, active-low                     |
// |               s_s/l_s/n_s   - EW straight / EW left / NS sensors (level)   |
// |               ped_req       - pedestrian button (pulse is latched)         |
// |               ew_str_light  - EW straight lamp colour                      |
// |               ew_left_light - EW left lamp colour                          |
// |               ns_light      - NS lamp colour                               |
// |               walk          - pedestrian walk lamp                         |
// |               phase         - phase holding or last holding right-of-way   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module traffic_phase_arbiter
  import light_package::*;
#(
  parameter int IDLE_CYC = C_IDLE_CYC,
  parameter int MAX_CYC  = C_MAX_CYC,
  parameter int YEL_CYC  = C_YEL_CYC,
  parameter int RED_CYC  = C_RED_CYC,
  parameter int WALK_CYC = C_WALK_CYC
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   s_s,
  input  logic   l_s,
  input  logic   n_s,
  input  logic   ped_req,
  output colors  ew_str_light,
  output colors  ew_left_light,
  output colors  ns_light,
  output logic   walk,
  output phase_t phase
);

  localparam int         NP          = C_NUM_PHASES;
  localparam logic [7:0] C_IDLE_LAST = 8'(IDLE_CYC - 1);
  localparam logic [7:0] C_MAX_LAST  = 8'(MAX_CYC - 1);
  localparam logic [7:0] C_YEL_LAST  = 8'(YEL_CYC - 1);
  localparam logic [7:0] C_RED_LAST  = 8'(RED_CYC - 1);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  phase_t        r_phase;
  phase_t        w_phase_nxt;
  logic [7:0]    r_ctr;
  logic [7:0]    r_gap_ctr;
  logic [7:0]    r_max_ctr;
  logic [7:0]    w_gap_nxt;
  logic [7:0]    w_max_nxt;
  logic [NP-1:0] r_req;
  logic [NP-1:0] w_req_in;
  logic [NP-1:0] w_phase_oh;
  logic [NP-1:0] w_clr;
  logic          w_other;
  logic          w_own;
  logic          w_pick_valid;
  phase_t        w_pick;

`ifdef TLC_PED_EN
  localparam logic [7:0] C_WALK_LAST = 8'(WALK_CYC - 1);
  assign w_req_in = {ped_req, n_s, l_s, s_s};
`else
  logic w_unused_ped;
  assign w_req_in     = {n_s, l_s, s_s};
  assign w_unused_ped = ped_req ^ (WALK_CYC == 0);
`endif

  // A phase's latched request is consumed for as long as it is green; a
  // sensor still held at that point simply re-asserts it every cycle.
  for (genvar gi = 0; gi < NP; gi++) begin : g_phase_dec
    assign w_phase_oh[gi] = (r_phase == phase_t'(2'(gi)));
    assign w_clr[gi]      = (r_state == GREEN) && w_phase_oh[gi];
  end

  assign w_other = |(r_req & ~w_phase_oh);

  always_comb begin
    w_own = 1'b0;
    case (r_phase)
      STR:     w_own = s_s;
      LEFT:    w_own = l_s;
      NS:      w_own = n_s;
      default: w_own = 1'b0;
    endcase
  end

  tlc_rr_pick #(
    .NUM_PHASES (NP)
  ) u_pick (
    .i_req   (r_req),
    .i_last  (r_phase),
    .o_grant (w_pick),
    .o_valid (w_pick_valid)
  );

  // Next-state logic. Gap and max counters only run in a vehicle green and
  // stay at zero everywhere else.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_gap_nxt   = 8'd0;
    w_max_nxt   = 8'd0;
    case (r_state)
      GREEN: begin
`ifdef TLC_PED_EN
        if (r_phase == PED) begin
          if (r_ctr == C_WALK_LAST) begin
            w_state_nxt = YELLOW;
          end
        end else
`endif
        begin
          if (w_other && !w_own) begin
            w_gap_nxt = r_gap_ctr + 8'd1;
          end
          if (w_other) begin
            w_max_nxt = r_max_ctr + 8'd1;
          end
          if ((w_other && !w_own && (r_gap_ctr == C_IDLE_LAST)) ||
              (w_other && (r_max_ctr == C_MAX_LAST))) begin
            w_state_nxt = YELLOW;
          end
        end
      end
      YELLOW: begin
        if (r_ctr == C_YEL_LAST) begin
          w_state_nxt = ALLRED;
        end
      end
      ALLRED: begin
        if ((r_ctr >= C_RED_LAST) && w_pick_valid) begin
          w_state_nxt = GREEN;
          w_phase_nxt = w_pick;
        end
      end
      default: begin
        w_state_nxt = ALLRED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ALLRED;
      r_phase   <= C_RESET_PHASE;
      r_ctr     <= 8'd0;
      r_gap_ctr <= 8'd0;
      r_max_ctr <= 8'd0;
      r_req     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_req   <= w_req_in | (r_req & ~w_clr);
      if (w_state_nxt != r_state) begin
        r_ctr     <= 8'd0;
        r_gap_ctr <= 8'd0;
        r_max_ctr <= 8'd0;
      end else begin
        // Saturate so an arbitrarily long idle all-red never wraps back
        // below the minimum red time.
        r_ctr     <= (r_ctr == 8'hFF) ? r_ctr : r_ctr + 8'd1;
        r_gap_ctr <= w_gap_nxt;
        r_max_ctr <= w_max_nxt;
      end
    end
  end

  // Lamp decode; anything not explicitly lit is red.
  always_comb begin
    ew_str_light  = LIGHT_RED;
    ew_left_light = LIGHT_RED;
    ns_light      = LIGHT_RED;
    walk          = 1'b0;
    case (r_state)
      GREEN: begin
        case (r_phase)
          STR:  ew_str_light  = LIGHT_GREEN;
          LEFT: ew_left_light = LIGHT_GREEN;
          NS:   ns_light      = LIGHT_GREEN;
`ifdef TLC_PED_EN
          PED:  walk          = 1'b1;
`endif
          default: begin
            walk = 1'b0;
          end
        endcase
      end
      YELLOW: begin
        case (r_phase)
          STR:  ew_str_light  = LIGHT_YELLOW;
          LEFT: ew_left_light = LIGHT_YELLOW;
          NS:   ns_light      = LIGHT_YELLOW;
          default: begin
            walk = 1'b0;
          end
        endcase
      end
      default: begin
        walk = 1'b0;
      end
    endcase
  end

  assign phase = r_phase;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_traffic_phase_arbiter                                     |
// | Description : Self-checking bench for traffic_phase_arbiter. A timeline    |
// |               model (mode, time in mode, conflict/idle run lengths) gives  |
// |               the expected lamps every cycle; directed scenarios pin the   |
// |               model with hand-derived durations and service order.         |
// |               Works with TLC_PED_EN defined or undefined.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_traffic_phase_arbiter;
  import light_package::*;

  localparam int P_IDLE = 5;
  localparam int P_MAX  = 10;
  localparam int P_YEL  = 2;
  localparam int P_RED  = 1;
  localparam int P_WALK = 4;
`ifdef TLC_PED_EN
  localparam int NP = 4;
`else
  localparam int NP = 3;
`endif

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  logic   s_s = 1'b0;
  logic   l_s = 1'b0;
  logic   n_s = 1'b0;
  logic   ped_req = 1'b0;
  colors  ew_str_light;
  colors  ew_left_light;
  colors  ns_light;
  logic   walk;
  phase_t phase;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  traffic_phase_arbiter #(
    .IDLE_CYC (P_IDLE),
    .MAX_CYC  (P_MAX),
    .YEL_CYC  (P_YEL),
    .RED_CYC  (P_RED),
    .WALK_CYC (P_WALK)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_s           (s_s),
    .l_s           (l_s),
    .n_s           (n_s),
    .ped_req       (ped_req),
    .ew_str_light  (ew_str_light),
    .ew_left_light (ew_left_light),
    .ns_light      (ns_light),
    .walk          (walk),
    .phase         (phase)
  );

  // ---------------- behavioural model ----------------
  // mode: 0 green, 1 yellow, 2 all-red. el = cycles already spent in mode.
  // conf = consecutive green cycles with a competing request,
  // idle = consecutive green cycles with a competitor and own sensor low.
  typedef struct packed {
    int         mode;
    int         ph;
    int         el;
    int         conf;
    int         idle;
    logic [3:0] pend;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t f_reset();
    mdl_t r;
    r.mode = 2; r.ph = NP - 1; r.el = 0; r.conf = 0; r.idle = 0; r.pend = 4'b0;
    return r;
  endfunction

  function automatic mdl_t f_step(mdl_t c, logic [3:0] in);
    mdl_t n;
    bit   other;
    bit   own;
    int   j;
    n = c;
    if (NP == 3) in[3] = 1'b0;
    n.el = (c.el < 1000) ? c.el + 1 : c.el;
    if (c.mode == 0) begin
      if (c.ph == 3) begin
        if (n.el == P_WALK) n.mode = 1;
      end else begin
        other = 1'b0;
        for (int k = 0; k < NP; k++) if (k != c.ph && c.pend[k]) other = 1'b1;
        own    = in[c.ph];
        n.conf = other ? c.conf + 1 : 0;
        n.idle = (other && !own) ? c.idle + 1 : 0;
        if (n.conf == P_MAX || n.idle == P_IDLE) n.mode = 1;
      end
    end else if (c.mode == 1) begin
      if (n.el == P_YEL) n.mode = 2;
    end else begin
      if (n.el >= P_RED) begin
        for (int k = 1; k <= NP; k++) begin
          j = (c.ph + k) % NP;
          if (c.pend[j] && n.mode == 2) begin
            n.mode = 0;
            n.ph   = j;
          end
        end
      end
    end
    if (n.mode != c.mode) begin
      n.el = 0; n.conf = 0; n.idle = 0;
    end
    for (int k = 0; k < 4; k++)
      n.pend[k] = in[k] | (c.pend[k] & !(c.mode == 0 && c.ph == k));
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= f_reset();
    else        m <= f_step(m, {ped_req, n_s, l_s, s_s});
  end

  // Expected {walk, str, left, ns, phase}
  function automatic logic [8:0] f_expect(mdl_t c);
    logic [1:0] lamp[3];
    logic       w;
    for (int k = 0; k < 3; k++) lamp[k] = LIGHT_RED;
    w = 1'b0;
    if (c.mode == 0 && c.ph < 3) lamp[c.ph] = LIGHT_GREEN;
    if (c.mode == 1 && c.ph < 3) lamp[c.ph] = LIGHT_YELLOW;
    if (c.mode == 0 && c.ph == 3) w = 1'b1;
    return {w, lamp[0], lamp[1], lamp[2], 2'(c.ph)};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({walk, ew_str_light, ew_left_light, ns_light, phase} != f_expect(m)) begin
        errors++;
        $display("FAIL model_cmp t=%0t actual(walk,str,left,ns,phase)=%h required=%h",
                 $time, {walk, ew_str_light, ew_left_light, ns_light, phase}, f_expect(m));
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // which: 0 str, 1 left, 2 ns, 3 "all vehicle lamps red"
  function automatic colors f_sel(input int which);
    case (which)
      0:       return ew_str_light;
      1:       return ew_left_light;
      2:       return ns_light;
      default: return (ew_str_light == LIGHT_RED && ew_left_light == LIGHT_RED &&
                       ns_light == LIGHT_RED) ? LIGHT_RED : LIGHT_GREEN;
    endcase
  endfunction

  task automatic count_run(input int which, input colors col, output int n);
    n = 0;
    while (f_sel(which) == col && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Cycles until a lamp turns green, counted at negedges.
  task automatic wait_green(input int which, output int n);
    n = 0;
    while (f_sel(which) != LIGHT_GREEN && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic int cur_green();
    if (ew_str_light == LIGHT_GREEN)  return 0;
    if (ew_left_light == LIGHT_GREEN) return 1;
    if (ns_light == LIGHT_GREEN)      return 2;
    if (walk)                         return 3;
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    s_s = 1'b0; l_s = 1'b0; n_s = 1'b0; ped_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  int n;
  int ord[5];
  int exp_ord[5];
  int nord;
  int walks;
  int prev;
  int g;
  int bad;

  initial begin
`ifdef TLC_PED_EN
    exp_ord = '{0, 1, 2, 3, 0};
`else
    exp_ord = '{0, 1, 2, 0, 1};
`endif
    repeat (2) @(negedge clk);
    check("reset_str", int'(ew_str_light), int'(LIGHT_RED));
    check("reset_left", int'(ew_left_light), int'(LIGHT_RED));
    check("reset_ns", int'(ns_light), int'(LIGHT_RED));
    check("reset_walk", int'(walk), 0);
    check("reset_phase", int'(phase), NP - 1);
    chk_en = 1'b1;
    reset  = 1'b1;
    @(negedge clk);

    // Lone straight demand: green after 2 edges, then held indefinitely.
    s_s = 1'b1;
    wait_green(0, n);
    check("str_green_latency", n, 2);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (ew_str_light != LIGHT_GREEN) bad++;
    end
    check("str_hold_100", bad, 0);

    // Competing NS pulse: max green, yellow, all-red, then NS.
    n_s = 1'b1;
    @(negedge clk);
    n_s = 1'b0;
    count_run(0, LIGHT_GREEN, n);
    check("max_green_len", n, P_MAX);
    count_run(0, LIGHT_YELLOW, n);
    check("max_yellow_len", n, P_YEL);
    count_run(3, LIGHT_RED, n);
    check("max_allred_len", n, P_RED);
    check("ns_green_after", int'(ns_light), int'(LIGHT_GREEN));

    // Reset during straight green forces red immediately.
    wait_green(0, n);
    check("str_regreen", int'(ew_str_light), int'(LIGHT_GREEN));
    reset = 1'b0;
    #1;
    check("async_reset_str", int'(ew_str_light), int'(LIGHT_RED));
    check("async_reset_walk", int'(walk), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_green(0, n);
    check("post_reset_latency", n, 2);

    // Left waits, straight sensor drops: idle gap ends green.
    l_s = 1'b1;
    repeat (2) @(negedge clk);
    s_s = 1'b0;
    count_run(0, LIGHT_GREEN, n);
    check("gap_green_len", n, P_IDLE);
    count_run(0, LIGHT_YELLOW, n);
    check("gap_yellow_len", n, P_YEL);
    count_run(3, LIGHT_RED, n);
    check("gap_allred_len", n, P_RED);
    check("left_green_after", int'(ew_left_light), int'(LIGHT_GREEN));
    l_s = 1'b0;

    // Everything requested at once: round-robin service order.
    do_reset();
    s_s = 1'b1; l_s = 1'b1; n_s = 1'b1; ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    nord = 0; walks = 0; prev = -1;
    for (int c = 0; c < 300 && nord < 5; c++) begin
      g = cur_green();
      if (walk) walks++;
      if (g >= 0 && g != prev) begin
        ord[nord] = g;
        nord++;
      end
      prev = g;
      @(negedge clk);
    end
    check("rr_entries", nord, 5);
    for (int k = 0; k < 5; k++) check($sformatf("rr_order_%0d", k), ord[k], exp_ord[k]);
`ifdef TLC_PED_EN
    check("walk_cycles", walks, P_WALK);
`else
    check("walk_cycles", walks, 0);
`endif

`ifndef TLC_PED_EN
    // Button ignored when the walk phase is compiled out.
    do_reset();
    s_s = 1'b1;
    wait_green(0, n);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      ped_req = c[0];
      @(negedge clk);
      if (walk !== 1'b0 || phase != STR) bad++;
    end
    ped_req = 1'b0;
    check("ped_ignored", bad, 0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(7) == 0) s_s = ~s_s;
      if ($urandom_range(7) == 0) l_s = ~l_s;
      if ($urandom_range(9) == 0) n_s = ~n_s;
      ped_req = ($urandom_range(24) == 0);
      if ($urandom_range(499) == 0) begin
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
